// File: rtl/mc_controller.sv
// Multicycle MIPS control sequencer: steps fetch/decode/execute/memory/writeback states.
// Latency: outputs are combinational from state (plus mem_ready/zero); FETCH-to-FETCH 2..5 cycles.
// Backpressure: holds FETCH, MEMRD and MEMWR with mem_req asserted until mem_ready.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       immext,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        IMMWB   = 4'd10,
        JEX     = 4'd11,
        ORIEX   = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_OR    = 2'd2,
        ALU_FUNCT = 2'd3
    } aluop_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur_state;
    state_t nxt_state;
    aluop_t aluop;
    logic   pcwrite;
    logic   branch;

    // State register; reset always returns to FETCH.
    always_ff @(posedge clk) begin
        if (reset) cur_state <= FETCH;
        else       cur_state <= nxt_state;
    end

    // Next-state logic; unused codes 13-15 fall back to FETCH.
    always_comb begin
        nxt_state = FETCH;
        case (cur_state)
            FETCH:   nxt_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt_state = MEMADR;
                    OP_RTYPE:     nxt_state = RTYPEEX;
                    OP_BEQ:       nxt_state = BEQEX;
                    OP_ADDI:      nxt_state = ADDIEX;
                    OP_ORI:       nxt_state = ORIEX;
                    OP_J:         nxt_state = JEX;
                    default:      nxt_state = FETCH;
                endcase
            end
            MEMADR:  nxt_state = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   nxt_state = mem_ready ? MEMWB : MEMRD;
            MEMWR:   nxt_state = mem_ready ? FETCH : MEMWR;
            RTYPEEX: nxt_state = RTYPEWB;
            ADDIEX:  nxt_state = IMMWB;
            ORIEX:   nxt_state = IMMWB;
            default: nxt_state = FETCH;
        endcase
    end

    // Per-state control outputs; reset forces every output low, aborting any access.
    always_comb begin
        mem_req  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        immext   = 1'b0;
        illegal  = 1'b0;
        aluop    = ALU_ADD;
        if (!reset) begin
            case (cur_state)
                FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    illegal = !(op == OP_LW || op == OP_SW || op == OP_RTYPE || op == OP_BEQ ||
                                op == OP_ADDI || op == OP_ORI || op == OP_J);
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                MEMWR: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = ALU_FUNCT;
                end
                RTYPEWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                BEQEX: begin
                    alusrca = 1'b1;
                    aluop   = ALU_SUB;
                    branch  = 1'b1;
                    pcsrc   = 2'b01;
                end
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                ORIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop   = ALU_OR;
                    immext  = 1'b1;
                end
                IMMWB: regwrite = 1'b1;
                JEX: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ALU decode; states that leave the ALU idle still present add, except under reset.
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            ALU_SUB: alucontrol = 3'b110;
            ALU_OR:  alucontrol = 3'b001;
            ALU_FUNCT: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
        if (reset || cur_state > ORIEX) alucontrol = 3'b000;
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = reset ? 4'd0 : cur_state;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       immext, illegal;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int n_chk  = 0;
    int n_fail = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .immext(immext), .alucontrol(alucontrol),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its hand-computed expectation.
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs settle well away from the edge.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ORI = 6'b001101, OP_J = 6'b000010;

    logic [3:0] lw_st   [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [2:0] lw_ctl  [6] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b110, 3'b000};
    logic [5:0] rt_fn   [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] rt_alu  [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    initial begin
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        tick; tick;
        reset = 1'b0; op = OP_SW; #1;
        check("reset_state", {4'd0, state}, 8'd0);
        check("fetch_irwrite", {7'd0, irwrite}, 8'd1);
        check("fetch_ctl", {3'd0, mem_req, pcen, alusrcb, 1'b0}, {3'd0, 1'b1, 1'b1, 2'b01, 1'b0});
        check("fetch_alu", {5'd0, alucontrol}, 8'd2);
        tick; check("sw_decode", {4'd0, state}, 8'd1);
        tick; check("sw_memadr", {4'd0, state}, 8'd2);
        check("memadr_src", {5'd0, alusrca, alusrcb}, {5'd0, 1'b1, 2'b10});
        tick; mem_ready = 1'b0; #1;
        check("sw_memwr", {4'd0, state}, 8'd5);
        check("memwr_ctl", {5'd0, mem_req, memwrite, iord}, 8'h07);
        reset = 1'b1; #1;
        check("reset_abort", {6'd0, mem_req, memwrite}, 8'd0);
        tick;
        check("reset_hold", {6'd0, mem_req, memwrite}, 8'd0);
        tick;
        reset = 1'b0; mem_ready = 1'b1; op = OP_LW; #1;
        check("post_reset_state", {4'd0, state}, 8'd0);
        check("post_reset_irwrite", {7'd0, irwrite}, 8'd1);

        // lw with zero-wait memory: 0,1,2,3,4,0.
        for (int i = 0; i < 6; i++) begin
            check($sformatf("lw_state%0d", i), {4'd0, state}, {4'd0, lw_st[i]});
            check($sformatf("lw_ctl%0d", i), {5'd0, regwrite, memtoreg, iord}, {5'd0, lw_ctl[i]});
            if (i < 5) tick;
        end

        // sw with three wait cycles in MEMWR.
        op = OP_SW;
        tick; tick; tick;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            check($sformatf("sw_stall%0d", i), {2'd0, state, mem_req, memwrite}, {2'd0, 4'd5, 2'b11});
            tick;
        end
        check("sw_return", {4'd0, state}, 8'd0);

        // beq taken then not taken.
        op = OP_BEQ; zero = 1'b1;
        tick; tick;
        check("beq_t_state", {4'd0, state}, 8'd8);
        check("beq_t_ctl", {3'd0, pcen, pcsrc, 2'b00}, {3'd0, 1'b1, 2'b01, 2'b00});
        check("beq_alu", {5'd0, alucontrol}, 8'd6);
        tick; check("beq_t_return", {4'd0, state}, 8'd0);
        zero = 1'b0;
        tick; tick;
        check("beq_nt_pcen", {3'd0, state, pcen}, {3'd0, 4'd8, 1'b0});
        tick; check("beq_nt_return", {4'd0, state}, 8'd0);

        // R-type, one per funct.
        op = 6'd0;
        for (int i = 0; i < 5; i++) begin
            funct = rt_fn[i];
            tick; tick;
            check($sformatf("rt_alu%0d", i), {1'b0, state, alucontrol}, {1'b0, 4'd6, rt_alu[i]});
            tick;
            check($sformatf("rt_wb%0d", i), {2'd0, state, regwrite, regdst}, {2'd0, 4'd7, 2'b11});
            tick;
            check($sformatf("rt_return%0d", i), {4'd0, state}, 8'd0);
        end

        // ori, j, illegal.
        op = OP_ORI;
        tick; tick;
        check("ori_state", {4'd0, state}, 8'd12);
        check("ori_ctl", {1'b0, immext, alusrcb, 1'b0, alucontrol}, {1'b0, 1'b1, 2'b10, 1'b0, 3'b001});
        tick; check("ori_wb", {3'd0, state, regwrite}, {3'd0, 4'd10, 1'b1});
        tick; check("ori_return", {4'd0, state}, 8'd0);
        op = OP_J;
        tick; tick;
        check("j_ctl", {1'b0, state, pcsrc, pcen}, {1'b0, 4'd11, 2'b10, 1'b1});
        tick; check("j_return", {4'd0, state}, 8'd0);
        op = 6'b111111;
        #1; check("illegal_fetch", {7'd0, illegal}, 8'd0);
        tick;
        check("illegal_decode", {3'd0, state, illegal}, {3'd0, 4'd1, 1'b1});
        tick;
        check("illegal_return", {3'd0, state, illegal}, {3'd0, 4'd0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
